// File: rtl/ps2_cmd_if.sv
// Command/response handshake between a host agent and the PS/2 command sequencer.
interface ps2_cmd_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       busy;
    logic       resp_valid;
    logic [7:0] resp_byte;
    logic [1:0] resp_err;

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, busy, resp_valid, resp_byte, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, busy, resp_valid, resp_byte, resp_err
    );
endinterface

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit, RTS, 11-bit TX frame, line ACK, response RX, resend on 0xFE.
// Optional macro PS2_PARITY_CHECK_EN adds odd-parity checking of the received response.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a command byte
// INHIBIT   | PS/2 clock held low for INHIBIT_CYCLES
// RTS       | clock released, data pulled low (start bit)
// TX        | shifting data/parity/stop on device clock falls, ACK on fall 11
// WAIT_IDLE | waiting for both lines high before the response frame
// RX        | sampling the 11-bit response frame on device clock falls
// EVAL      | classify response: ok, resend, or error
// RESULT    | one-cycle resp_valid strobe
module ps2_cmd_ctrl #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    ps2_cmd_if.slave  cmd,
    input  logic      ps2_clk_in,
    input  logic      ps2_data_in,
    output logic      ps2_clk_oe,
    output logic      ps2_data_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [RTY_W-1:0] MAX_RTY  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_TX, S_WAIT_IDLE, S_RX, S_EVAL, S_RESULT
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cmd_byte_q, cmd_byte_d;
    logic              par_q, par_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              drive_q, drive_d;
    logic [10:0]       rx_q, rx_d;
    logic [INH_W-1:0]  inh_q, inh_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        err_q, err_d;
    logic [7:0]        resp_byte_q, resp_byte_d;
    logic              rdy_q;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic fall, tmo_hit, par_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q;

    // A device clock fall in the terminal-count cycle takes priority over the timeout.
    assign tmo_hit = (state_q inside {S_RTS, S_TX, S_WAIT_IDLE, S_RX}) && (tmo_q == '0) && !fall;

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^rx_q[9:1];
`else
    logic par_unused;
    assign par_unused = rx_q[9];
    assign par_ok     = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_byte_d  = cmd_byte_q;
        par_d       = par_q;
        retry_d     = retry_q;
        bit_idx_d   = bit_idx_q;
        drive_d     = drive_q;
        rx_d        = rx_q;
        inh_d       = inh_q;
        err_d       = err_q;
        resp_byte_d = resp_byte_q;

        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && rdy_q) begin
                    cmd_byte_d = cmd.cmd_data;
                    par_d      = ~^cmd.cmd_data;
                    retry_d    = '0;
                    inh_d      = INH_LOAD;
                    state_d    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_q == '0) state_d = S_RTS;
                else             inh_d   = inh_q - INH_W'(1);
            end
            S_RTS: begin
                if (tmo_hit) begin
                    err_d   = 2'd1;
                    state_d = S_RESULT;
                end else begin
                    drive_d   = 1'b1;
                    bit_idx_d = '0;
                    state_d   = S_TX;
                end
            end
            S_TX: begin
                if (fall) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q < 4'd8) begin
                        drive_d = ~cmd_byte_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == 4'd8) begin
                        drive_d = ~par_q;
                    end else if (bit_idx_q == 4'd9) begin
                        drive_d = 1'b0;
                    end else if (data_sync_q) begin
                        err_d   = 2'd2;
                        state_d = S_RESULT;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end else if (tmo_hit) begin
                    err_d   = 2'd1;
                    state_d = S_RESULT;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    bit_idx_d = '0;
                    state_d   = S_RX;
                end else if (tmo_hit) begin
                    err_d   = 2'd1;
                    state_d = S_RESULT;
                end
            end
            S_RX: begin
                if (fall) begin
                    rx_d      = {data_sync_q, rx_q[10:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd10) state_d = S_EVAL;
                end else if (tmo_hit) begin
                    err_d   = 2'd1;
                    state_d = S_RESULT;
                end
            end
            S_EVAL: begin
                resp_byte_d = rx_q[8:1];
                state_d     = S_RESULT;
                if (rx_q[0] || !rx_q[10] || !par_ok) begin
                    err_d = 2'd2;
                end else if (rx_q[8:1] == 8'hFA) begin
                    err_d = 2'd0;
                end else if (rx_q[8:1] == 8'hFE && retry_q < MAX_RTY) begin
                    retry_d = retry_q + RTY_W'(1);
                    inh_d   = INH_LOAD;
                    state_d = S_INHIBIT;
                end else begin
                    err_d = 2'd3;
                end
            end
            S_RESULT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        tmo_d = tmo_q;
        if (fall || state_d != state_q) tmo_d = TMO_LOAD;
        else if (tmo_q != '0)           tmo_d = tmo_q - TMO_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_byte_q  <= '0;
            par_q       <= 1'b0;
            retry_q     <= '0;
            bit_idx_q   <= '0;
            drive_q     <= 1'b0;
            rx_q        <= '0;
            inh_q       <= '0;
            tmo_q       <= TMO_LOAD;
            err_q       <= '0;
            resp_byte_q <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_byte_q  <= cmd_byte_d;
            par_q       <= par_d;
            retry_q     <= retry_d;
            bit_idx_q   <= bit_idx_d;
            drive_q     <= drive_d;
            rx_q        <= rx_d;
            inh_q       <= inh_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            resp_byte_q <= resp_byte_d;
            rdy_q       <= 1'b1;
        end
    end

    // Line drivers decode straight from state so reset and aborts release the pins without a clock.
    assign ps2_clk_oe  = (state_q == S_INHIBIT);
    assign ps2_data_oe = ((state_q == S_RTS) || (state_q == S_TX && drive_q)) && !tmo_hit;

    assign cmd.cmd_ready  = rdy_q && (state_q == S_IDLE);
    assign cmd.busy       = (state_q != S_IDLE);
    assign cmd.resp_valid = (state_q == S_RESULT);
    assign cmd.resp_byte  = resp_byte_q;
    assign cmd.resp_err   = err_q;

endmodule
